// File: rtl/text_line_scheduler_pkg.sv
// Shared definitions for the text line scheduler.
//   CHAR_W, CHAR_H : glyph cell size in pixels; fixed by the glyph ROM
//   wr_state_e     : host write FSM state encoding
//   BLANK_CHAR     : character code used to initialise the line buffers
package text_line_scheduler_pkg;

    localparam int unsigned CHAR_W = 16;
    localparam int unsigned CHAR_H = 32;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StLoading = 2'd1,
        StPending = 2'd2
    } wr_state_e;

    localparam logic [7:0] BLANK_CHAR = 8'd32;

endpackage

// File: rtl/text_line_buffer.sv
// Double-buffered character store. The host fills the back buffer; a single
// swap strobe copies the whole back buffer into the active buffer, which is
// what scan-out reads.
//   clk, reset_n       : pixel clock, synchronous active-low reset
//   wr_en/idx/data     : back-buffer write port
//   swap               : copy back buffer into active buffer
//   rd_idx -> rd_data  : combinational active-buffer read port
module text_line_buffer
    import text_line_scheduler_pkg::*;
#(
    parameter int unsigned MAX_CHARS = 16,
    parameter int unsigned IDX_W     = $clog2(MAX_CHARS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [7:0]       wr_data,
    input  logic             swap,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [7:0]       rd_data
);

    logic [7:0] back_q   [MAX_CHARS];
    logic [7:0] active_q [MAX_CHARS];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(MAX_CHARS); i++) begin
                back_q[i]   <= BLANK_CHAR;
                active_q[i] <= BLANK_CHAR;
            end
        end else begin
            if (wr_en) begin
                back_q[wr_idx] <= wr_data;
            end
            if (swap) begin
                for (int i = 0; i < int'(MAX_CHARS); i++) begin
                    active_q[i] <= back_q[i];
                end
            end
        end
    end

    assign rd_data = active_q[rd_idx];

endmodule

// File: rtl/text_line_scheduler.sv
// Scans one line of text through the 16x32 glyph ROM for the VGA overlay.
// The host loads a string into a back buffer over a valid/ready port; the
// string becomes visible only at the next frame_start after it is complete.
// Scan-out maps x,y to a character cell, drives the ROM (stage 1) and
// registers the ROM result into pixel_on (stage 2): two clocks of latency.
//
// Ports:
//   clk, reset_n                  : pixel clock, synchronous active-low reset
//   wr_valid, wr_char, wr_last    : host character stream
//   wr_ready                      : a character is accepted this cycle if valid
//   load_pending                  : complete string waiting for frame swap
//   x, y, video_on, frame_start   : scan position and timing
//   font_code, font_start_x/y     : character and cell origin to glyph ROM
//   font_x, font_y                : registered scan position to glyph ROM
//   font_on                       : glyph ROM pixel (combinational from font_*)
//   pixel_on                      : text pixel lit
//
// Optional build macro CURSOR_BLINK_EN: adds a cursor cell just after the last
// character that blinks with a 32-frame period.
module text_line_scheduler
    import text_line_scheduler_pkg::*;
#(
    parameter int unsigned MAX_CHARS = 16,
    parameter int unsigned ORIGIN_X  = 64,
    parameter int unsigned ORIGIN_Y  = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr_valid,
    input  logic [7:0] wr_char,
    input  logic       wr_last,
    output logic       wr_ready,
    output logic       load_pending,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       video_on,
    input  logic       frame_start,
    output logic [7:0] font_code,
    output logic [9:0] font_start_x,
    output logic [9:0] font_start_y,
    output logic [9:0] font_x,
    output logic [9:0] font_y,
    input  logic       font_on,
    output logic       pixel_on
);

    localparam int unsigned IDX_W      = $clog2(MAX_CHARS);
    localparam int unsigned LEN_W      = IDX_W + 1;
    localparam int unsigned CELL_SHIFT = $clog2(CHAR_W);

    // ------------------------------------------------------------------
    // Host write FSM
    // ------------------------------------------------------------------
    wr_state_e        state_q, state_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [LEN_W-1:0] active_len_q, active_len_d;
    logic [IDX_W-1:0] wr_idx;
    logic             accept;
    logic             swap;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        active_len_d = active_len_q;
        wr_ready     = 1'b0;
        load_pending = 1'b0;
        accept       = 1'b0;
        swap         = 1'b0;
        wr_idx       = '0;
        unique case (state_q)
            StIdle: begin
                wr_ready = 1'b1;
                accept   = wr_valid;
                if (accept) begin
                    count_d = LEN_W'(1);
                    state_d = wr_last ? StPending : StLoading;
                end
            end
            StLoading: begin
                wr_ready = 1'b1;
                accept   = wr_valid;
                wr_idx   = count_q[IDX_W-1:0];
                if (accept) begin
                    count_d = count_q + LEN_W'(1);
                    // A full buffer terminates the string even without wr_last.
                    if (wr_last || (wr_idx == IDX_W'(MAX_CHARS - 1))) begin
                        state_d = StPending;
                    end
                end
            end
            StPending: begin
                load_pending = 1'b1;
                if (frame_start) begin
                    swap         = 1'b1;
                    active_len_d = count_q;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            count_q      <= '0;
            active_len_q <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            active_len_q <= active_len_d;
        end
    end

    // ------------------------------------------------------------------
    // Character storage
    // ------------------------------------------------------------------
    logic [9:0] dx;
    logic [9:0] col;
    logic [7:0] rd_data;

    text_line_buffer #(
        .MAX_CHARS (MAX_CHARS),
        .IDX_W     (IDX_W)
    ) u_buffer (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (accept),
        .wr_idx  (wr_idx),
        .wr_data (wr_char),
        .swap    (swap),
        .rd_idx  (col[IDX_W-1:0]),
        .rd_data (rd_data)
    );

    // ------------------------------------------------------------------
    // Cell mapping
    // ------------------------------------------------------------------
    logic in_line;
    logic hit;
    logic draw_cell;
    logic cursor_lit;
    logic [9:0] cell_x;

    assign dx      = x - 10'(ORIGIN_X);
    assign col     = dx >> CELL_SHIFT;
    assign in_line = video_on && (x >= 10'(ORIGIN_X)) && (y >= 10'(ORIGIN_Y)) &&
                     (y < 10'(ORIGIN_Y + CHAR_H));
    // Truncating col for the read index is safe: the read data only matters
    // when col < active_len <= MAX_CHARS (or col == active_len < MAX_CHARS).
    assign hit     = in_line && (col < 10'(active_len_q));
    assign cell_x  = 10'(ORIGIN_X) + (col << CELL_SHIFT);

`ifdef CURSOR_BLINK_EN
    logic [4:0] frame_cnt_q;
    logic       cursor_cell;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frame_cnt_q <= '0;
        end else if (frame_start) begin
            frame_cnt_q <= frame_cnt_q + 5'd1;
        end
    end

    assign cursor_cell = in_line && (col == 10'(active_len_q)) &&
                         (active_len_q < LEN_W'(MAX_CHARS));
    // Blink phase is captured with the pixel so both stages see one frame.
    assign cursor_lit  = cursor_cell && frame_cnt_q[4];
    assign draw_cell   = hit || cursor_cell;
`else
    assign cursor_lit  = 1'b0;
    assign draw_cell   = hit;
`endif

    // ------------------------------------------------------------------
    // Two-stage pixel pipeline
    // ------------------------------------------------------------------
    logic [7:0] font_code_q;
    logic [9:0] font_start_x_q, font_start_y_q, font_x_q, font_y_q;
    logic       hit_q, cursor_lit_q, pixel_on_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            font_code_q    <= '0;
            font_start_x_q <= '0;
            font_start_y_q <= '0;
            font_x_q       <= '0;
            font_y_q       <= '0;
            hit_q          <= 1'b0;
            cursor_lit_q   <= 1'b0;
            pixel_on_q     <= 1'b0;
        end else begin
            font_code_q    <= draw_cell ? rd_data : 8'd0;
            font_start_x_q <= cell_x;
            font_start_y_q <= 10'(ORIGIN_Y);
            font_x_q       <= x;
            font_y_q       <= y;
            hit_q          <= hit;
            cursor_lit_q   <= cursor_lit;
            pixel_on_q     <= (hit_q && font_on) || cursor_lit_q;
        end
    end

    assign font_code    = font_code_q;
    assign font_start_x = font_start_x_q;
    assign font_start_y = font_start_y_q;
    assign font_x       = font_x_q;
    assign font_y       = font_y_q;
    assign pixel_on     = pixel_on_q;

endmodule

// File: tb/tb_text_line_scheduler.sv
// Self-checking bench for text_line_scheduler: a reference model of the
// host string / frame swap and the pixel-to-cell mapping runs alongside the
// DUT, plus a table of hand-picked pixels and directed corner sequences.
module tb_text_line_scheduler;

    localparam int MAXC = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_valid, wr_last, wr_ready, load_pending;
    logic [7:0] wr_char;
    logic [9:0] x, y;
    logic       video_on, frame_start;
    logic [7:0] font_code;
    logic [9:0] font_start_x, font_start_y, font_x, font_y;
    logic       font_on, pixel_on;

    always #5 clk = ~clk;

    text_line_scheduler dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_valid     (wr_valid),
        .wr_char      (wr_char),
        .wr_last      (wr_last),
        .wr_ready     (wr_ready),
        .load_pending (load_pending),
        .x            (x),
        .y            (y),
        .video_on     (video_on),
        .frame_start  (frame_start),
        .font_code    (font_code),
        .font_start_x (font_start_x),
        .font_start_y (font_start_y),
        .font_x       (font_x),
        .font_y       (font_y),
        .font_on      (font_on),
        .pixel_on     (pixel_on)
    );

    // Glyph ROM stand-in: either all ones or a code/position dependent pattern.
    bit         rom_ones;
    logic [9:0] rom_px, rom_py;

    function automatic bit rom_fn(int code, int px, int py);
        return ((code + px + py) % 3) == 0;
    endfunction

    assign rom_px  = font_x - font_start_x;
    assign rom_py  = font_y - font_start_y;
    assign font_on = rom_ones | rom_fn(int'(font_code), int'(rom_px), int'(rom_py));

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    int back_arr [MAXC];
    int act_arr  [MAXC];
    int back_len, act_len, frames;
    bit pend;
    bit e_prev, prev_valid;

    int vectors = 0;
    int fails   = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected results for the current x/y/video_on against the visible string.
    task automatic expect_now(output bit pix, output bit code_chk, output int code,
                              output bit hit_o, output int sx);
        int  xi  = int'(x);
        int  yi  = int'(y);
        bit  inl = video_on && xi >= 64 && yi >= 32 && yi < 64;
        int  col = (xi - 64) / 16;
        hit_o    = inl && col < act_len;
        code_chk = 1'b1;
        code     = hit_o ? act_arr[col] : 0;
        sx       = 64 + col * 16;
        pix      = hit_o ? (rom_ones ? 1'b1 : rom_fn(act_arr[col], (xi - 64) % 16, yi - 32))
                         : 1'b0;
`ifdef CURSOR_BLINK_EN
        if (inl && col == act_len && act_len < MAXC) begin
            pix      = (frames % 32) >= 16;
            code_chk = 1'b0;
        end
`endif
    endtask

    // One clock: predict, advance model at the edge, compare just after.
    task automatic cycle();
        bit e_pix, e_cc, e_hit, acc;
        int e_code, e_sx, xs, ys;
        expect_now(e_pix, e_cc, e_code, e_hit, e_sx);
        acc = wr_valid && !pend;
        xs  = int'(x);
        ys  = int'(y);
        @(posedge clk);
        if (pend && frame_start) begin
            act_arr  = back_arr;
            act_len  = back_len;
            back_len = 0;
            pend     = 1'b0;
        end else if (acc) begin
            back_arr[back_len] = int'(wr_char);
            back_len++;
            if (wr_last || back_len == MAXC) pend = 1'b1;
        end
        if (frame_start) frames++;
        #1;
        check("wr_ready", 32'(wr_ready), 32'(!pend));
        check("load_pending", 32'(load_pending), 32'(pend));
        check("font_x", 32'(font_x), xs);
        check("font_y", 32'(font_y), ys);
        check("font_start_y", 32'(font_start_y), 32);
        if (e_cc) check("font_code", 32'(font_code), e_code);
        if (e_hit) check("font_start_x", 32'(font_start_x), e_sx);
        if (prev_valid) check("pixel_on", 32'(pixel_on), 32'(e_prev));
        e_prev     = e_pix;
        prev_valid = 1'b1;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        wr_valid    = 1'b0;
        wr_last     = 1'b0;
        wr_char     = 8'd0;
        video_on    = 1'b0;
        frame_start = 1'b0;
        x           = 10'd0;
        y           = 10'd0;
        repeat (3) @(posedge clk);
        #1;
        back_len   = 0;
        act_len    = 0;
        frames     = 0;
        pend       = 1'b0;
        e_prev     = 1'b0;
        prev_valid = 1'b1;
        reset_n    = 1'b1;
    endtask

    task automatic beat(int ch, bit last, bit fs);
        wr_valid    = 1'b1;
        wr_char     = 8'(ch);
        wr_last     = last;
        frame_start = fs;
        cycle();
        wr_valid    = 1'b0;
        wr_last     = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        cycle();
        frame_start = 1'b0;
    endtask

    task automatic scan(int y0, int y1, int x0, int x1, int stp);
        video_on = 1'b1;
        for (int yy = y0; yy <= y1; yy++) begin
            for (int xx = x0; xx <= x1; xx += stp) begin
                x = 10'(xx);
                y = 10'(yy);
                cycle();
            end
        end
        video_on = 1'b0;
    endtask

    task automatic probe(string name, int px, int py, bit exp);
        x        = 10'(px);
        y        = 10'(py);
        video_on = 1'b1;
        cycle();
        video_on = 1'b0;
        cycle();
        check(name, 32'(pixel_on), 32'(exp));
    endtask

    typedef struct {
        int x;
        int y;
        bit vid;
        int code;
        int sx;
        bit pix;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{64, 36, 1'b1, 65, 64, 1'b1};
        tbl[1] = '{79, 36, 1'b1, 65, 64, 1'b1};
        tbl[2] = '{80, 36, 1'b1, 66, 80, 1'b1};
        tbl[3] = '{111, 63, 1'b1, 67, 96, 1'b1};
        tbl[4] = '{128, 36, 1'b1, 0, -1, 1'b0};
        tbl[5] = '{63, 36, 1'b1, 0, -1, 1'b0};
        tbl[6] = '{100, 31, 1'b1, 0, -1, 1'b0};
        tbl[7] = '{100, 32, 1'b1, 67, 96, 1'b1};
        tbl[8] = '{100, 64, 1'b1, 0, -1, 1'b0};
        tbl[9] = '{70, 40, 1'b0, 0, -1, 1'b0};

        rom_ones = 1'b0;

        // Reset state
        do_reset();
        check("rst_wr_ready", 32'(wr_ready), 1);
        check("rst_load_pending", 32'(load_pending), 0);
        check("rst_pixel_on", 32'(pixel_on), 0);
        check("rst_font_code", 32'(font_code), 0);
        check("rst_font_start_x", 32'(font_start_x), 0);
        check("rst_font_start_y", 32'(font_start_y), 0);
        check("rst_font_x", 32'(font_x), 0);
        check("rst_font_y", 32'(font_y), 0);

        // Empty line draws nothing over a frame
        frame();
        scan(28, 66, 40, 160, 8);

        // Mid-frame load of "ABC": pending at once, visible only after swap
        frame();
        scan(32, 34, 56, 120, 8);
        beat(65, 1'b0, 1'b0);
        beat(66, 1'b0, 1'b0);
        beat(67, 1'b1, 1'b0);
        check("abc_wr_ready", 32'(wr_ready), 0);
        check("abc_load_pending", 32'(load_pending), 1);
        scan(32, 40, 56, 120, 4);
        rom_ones = 1'b1;
        frame();

        // Table of pixels against the visible "ABC" with an all-ones ROM
        for (int i = 0; i < 10; i++) begin
            x        = 10'(tbl[i].x);
            y        = 10'(tbl[i].y);
            video_on = tbl[i].vid;
            cycle();
            check("tbl_font_code", 32'(font_code), tbl[i].code);
            if (tbl[i].sx >= 0) check("tbl_font_start_x", 32'(font_start_x), tbl[i].sx);
            video_on = 1'b0;
            cycle();
            check("tbl_pixel_on", 32'(pixel_on), 32'(tbl[i].pix));
        end

        // 20 beats without wr_last: buffer fills at 16, rest stall
        for (int i = 0; i < 20; i++) begin
            beat(97 + i, 1'b0, 1'b0);
            if (i == 14) check("fill15_load_pending", 32'(load_pending), 0);
            if (i == 15) check("fill16_load_pending", 32'(load_pending), 1);
            if (i >= 15) check("fill_wr_ready", 32'(wr_ready), 0);
        end
        frame();
        probe("cell15_left", 304, 40, 1'b1);
        probe("cell15_right", 319, 63, 1'b1);
        probe("past_cell15", 320, 40, 1'b0);

        // Last beat coincides with frame_start: swap deferred one frame
        beat(88, 1'b0, 1'b0);
        beat(89, 1'b1, 1'b1);
        check("coinc_load_pending", 32'(load_pending), 1);
        probe("coinc_old_line", 100, 40, 1'b1);
        frame();
        check("coinc_swapped", 32'(load_pending), 0);
        probe("coinc_new_short", 100, 40, 1'b0);
        probe("coinc_new_cell1", 80, 40, 1'b1);

        // Randomized traffic against the model
        rom_ones = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            wr_valid    = ($urandom % 3) == 0;
            wr_char     = 8'($urandom);
            wr_last     = ($urandom % 6) == 0;
            frame_start = ($urandom % 150) == 0;
            x           = 10'(40 + $urandom % 300);
            y           = 10'(20 + $urandom % 60);
            video_on    = ($urandom % 8) != 0;
            cycle();
        end
        wr_valid    = 1'b0;
        wr_last     = 1'b0;
        frame_start = 1'b0;
        video_on    = 1'b0;
        cycle();
        cycle();

        // Reset during LOADING discards the partial string and the active line
        rom_ones = 1'b1;
        beat(1, 1'b0, 1'b0);
        beat(2, 1'b0, 1'b0);
        do_reset();
        check("rst_mid_load_pending", 32'(load_pending), 0);
        check("rst_mid_wr_ready", 32'(wr_ready), 1);
        frame();
        probe("rst_mid_dark", 70, 40, 1'b0);
        beat(5, 1'b1, 1'b0);
        check("post_rst_pending", 32'(load_pending), 1);

`ifdef CURSOR_BLINK_EN
        // Two-character line; the cursor cell x=96..111 follows the blink phase
        frame();
        beat(65, 1'b0, 1'b0);
        beat(66, 1'b1, 1'b0);
        for (int f = 0; f < 40; f++) begin
            frame();
            probe("cursor_cell", 100, 40, (frames % 32) >= 16);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
